// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath constants for the register file and destination selector
package cpu_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 0;
  localparam int RA_REG   = 31;
endpackage

// File: rtl/grf_read_port.sv
// rtl/grf_read_port.sv - one GRF read port: register-0 forcing and optional write bypass
module grf_read_port #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter bit FORWARD = 1'b1
) (
  input  logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] stored,
  input  logic              fwd_valid,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
);
  import cpu_pkg::*;

  always_comb begin
    rd = stored;
    if (FORWARD && fwd_valid && (wa == ra)) rd = wd;
    // register 0 wins over any bypass
    if (ra == ADDR_W'(ZERO_REG)) rd = '0;
  end
endmodule

// File: rtl/grf_bypass.sv
// rtl/grf_bypass.sv - 32-entry register file with write bypass, write trace and commit counter
module grf_bypass #(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter bit FORWARD = 1'b1,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               we,
  input  logic [ADDR_W-1:0]  wa,
  input  logic [DATA_W-1:0]  wd,
  input  logic [31:0]        pc,
  input  logic [ADDR_W-1:0]  ra1,
  input  logic [ADDR_W-1:0]  ra2,
  output logic [DATA_W-1:0]  rd1,
  output logic [DATA_W-1:0]  rd2,
  output logic               trace_valid,
  output logic [31:0]        trace_pc,
  output logic [ADDR_W-1:0]  trace_addr,
  output logic [DATA_W-1:0]  trace_data,
  output logic [COUNT_W-1:0] write_count
);
  import cpu_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              commit;
  logic              fwd_valid;

  // wa == 0 is the discarded-link case: no array, trace or counter effect
  assign commit    = we && (wa != ADDR_W'(ZERO_REG));
  assign fwd_valid = commit && reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      trace_valid <= 1'b0;
      trace_pc    <= '0;
      trace_addr  <= '0;
      trace_data  <= '0;
      write_count <= '0;
    end else begin
      trace_valid <= commit;
      if (commit) begin
        regs[wa]    <= wd;
        trace_pc    <= pc;
        trace_addr  <= wa;
        trace_data  <= wd;
        write_count <= write_count + COUNT_W'(1);
      end
    end
  end

  grf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FORWARD(FORWARD)) u_port1 (
    .ra        (ra1),
    .stored    (regs[ra1]),
    .fwd_valid (fwd_valid),
    .wa        (wa),
    .wd        (wd),
    .rd        (rd1)
  );

  grf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FORWARD(FORWARD)) u_port2 (
    .ra        (ra2),
    .stored    (regs[ra2]),
    .fwd_valid (fwd_valid),
    .wa        (wa),
    .wd        (wd),
    .rd        (rd2)
  );
endmodule

// File: tb/tb_grf_bypass.sv
// tb/tb_grf_bypass.sv - self-checking bench for grf_bypass with and without bypass
module tb_grf_bypass;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        we;
  logic [4:0]  wa, ra1, ra2;
  logic [31:0] wd, pc;

  logic [31:0] f_rd1, f_rd2, f_tpc, f_td, n_rd1, n_rd2, n_tpc, n_td;
  logic [4:0]  f_ta, n_ta;
  logic        f_tv, n_tv;
  logic [15:0] f_wc, n_wc;

  int total = 0;
  int bad   = 0;

  logic [31:0] mreg [32];
  int          mcnt;
  logic        mtv;
  logic [31:0] mtpc, mtd;
  logic [4:0]  mta;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] f1, f2, n1, n2;
    logic        tv;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [5];

  always #5 clk = ~clk;

  grf_bypass #(.DATA_W(32), .ADDR_W(5), .FORWARD(1'b1), .COUNT_W(16)) u_f (
    .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd), .pc(pc),
    .ra1(ra1), .ra2(ra2), .rd1(f_rd1), .rd2(f_rd2),
    .trace_valid(f_tv), .trace_pc(f_tpc), .trace_addr(f_ta), .trace_data(f_td),
    .write_count(f_wc)
  );

  grf_bypass #(.DATA_W(32), .ADDR_W(5), .FORWARD(1'b0), .COUNT_W(16)) u_n (
    .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd), .pc(pc),
    .ra1(ra1), .ra2(ra2), .rd1(n_rd1), .rd2(n_rd2),
    .trace_valid(n_tv), .trace_pc(n_tpc), .trace_addr(n_ta), .trace_data(n_td),
    .write_count(n_wc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    mcnt = 0; mtv = 1'b0; mtpc = '0; mtd = '0; mta = '0;
  endtask

  function automatic logic [31:0] exp_rd(input logic fwd, input logic [4:0] ra);
    if (ra == 5'd0) return 32'h0;
    if (!reset_n) return 32'h0;
    if (fwd && we && wa != 5'd0 && wa == ra) return wd;
    return mreg[ra];
  endfunction

  task automatic set_in(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic [31:0] p, input logic [4:0] r1, input logic [4:0] r2);
    we = w; wa = a; wd = d; pc = p; ra1 = r1; ra2 = r2;
  endtask

  task automatic check_reads(input string tag);
    chk({tag, " f_rd1"}, f_rd1, exp_rd(1'b1, ra1));
    chk({tag, " f_rd2"}, f_rd2, exp_rd(1'b1, ra2));
    chk({tag, " n_rd1"}, n_rd1, exp_rd(1'b0, ra1));
    chk({tag, " n_rd2"}, n_rd2, exp_rd(1'b0, ra2));
  endtask

  // advance one edge and move the model by the commit rule
  task automatic clock_edge();
    @(posedge clk);
    if (reset_n && we && wa != 5'd0) begin
      mreg[wa] = wd; mcnt++; mtv = 1'b1; mtpc = pc; mta = wa; mtd = wd;
    end else begin
      mtv = 1'b0;
    end
    #1;
  endtask

  task automatic check_trace(input string tag);
    chk({tag, " f_tv"}, 32'(f_tv), 32'(mtv));
    chk({tag, " n_tv"}, 32'(n_tv), 32'(mtv));
    chk({tag, " f_tpc"}, f_tpc, mtpc);
    chk({tag, " f_ta"}, 32'(f_ta), 32'(mta));
    chk({tag, " f_td"}, f_td, mtd);
    chk({tag, " n_td"}, n_td, mtd);
    chk({tag, " f_wc"}, 32'(f_wc), 32'(16'(mcnt)));
    chk({tag, " n_wc"}, 32'(n_wc), 32'(16'(mcnt)));
  endtask

  initial begin
    tbl[0] = '{1'b1, 5'd8, 32'hDEADBEEF, 32'h3000, 5'd8, 5'd0,
               32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 1'b1, 16'd1};
    tbl[1] = '{1'b1, 5'd0, 32'hFFFFFFFF, 32'h3004, 5'd0, 5'd8,
               32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0, 16'd1};
    tbl[2] = '{1'b1, 5'd3, 32'h11, 32'h3008, 5'd3, 5'd3,
               32'h11, 32'h11, 32'h0, 32'h0, 1'b1, 16'd2};
    tbl[3] = '{1'b1, 5'd3, 32'h22, 32'h300C, 5'd3, 5'd3,
               32'h22, 32'h22, 32'h11, 32'h11, 1'b1, 16'd3};
    tbl[4] = '{1'b0, 5'd3, 32'h99, 32'h3010, 5'd3, 5'd8,
               32'h22, 32'hDEADBEEF, 32'h22, 32'hDEADBEEF, 1'b0, 16'd3};

    reset_n = 1'b0;
    set_in(1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd8);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset f_rd1", f_rd1, 32'h0);
    chk("reset f_tv", 32'(f_tv), 32'h0);
    chk("reset f_wc", 32'(f_wc), 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      set_in(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].pc, tbl[i].ra1, tbl[i].ra2);
      @(negedge clk);
      chk($sformatf("vec%0d f_rd1", i), f_rd1, tbl[i].f1);
      chk($sformatf("vec%0d f_rd2", i), f_rd2, tbl[i].f2);
      chk($sformatf("vec%0d n_rd1", i), n_rd1, tbl[i].n1);
      chk($sformatf("vec%0d n_rd2", i), n_rd2, tbl[i].n2);
      clock_edge();
      chk($sformatf("vec%0d f_tv", i), 32'(f_tv), 32'(tbl[i].tv));
      chk($sformatf("vec%0d n_tv", i), 32'(n_tv), 32'(tbl[i].tv));
      chk($sformatf("vec%0d f_wc", i), 32'(f_wc), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d n_wc", i), 32'(n_wc), 32'(tbl[i].cnt));
      if (i == 0) begin
        chk("vec0 trace_addr", 32'(f_ta), 32'd8);
        chk("vec0 trace_data", f_td, 32'hDEADBEEF);
        chk("vec0 trace_pc", f_tpc, 32'h3000);
      end
    end

    // back-to-back commits: link register, r1, link register again
    set_in(1'b1, 5'd31, 32'h3004, 32'h100, 5'd31, 5'd1);
    clock_edge(); check_trace("b2b0");
    set_in(1'b1, 5'd1, 32'h7, 32'h104, 5'd31, 5'd1);
    clock_edge(); check_trace("b2b1");
    set_in(1'b1, 5'd31, 32'h3010, 32'h108, 5'd31, 5'd1);
    clock_edge(); check_trace("b2b2");
    chk("b2b tv third", 32'(f_tv), 32'h1);
    set_in(1'b0, 5'd0, 32'h0, 32'h0, 5'd31, 5'd1);
    @(negedge clk);
    chk("b2b r31", n_rd1, 32'h3010);
    chk("b2b r1", n_rd2, 32'h7);
    clock_edge(); check_trace("b2b idle");

    // asynchronous reset between edges, with a bypass pending
    set_in(1'b1, 5'd5, 32'h1234, 32'h200, 5'd5, 5'd5);
    clock_edge();
    set_in(1'b1, 5'd5, 32'h5555, 32'h204, 5'd5, 5'd8);
    #1;
    chk("pre-rst bypass", f_rd1, 32'h5555);
    chk("pre-rst stored", n_rd1, 32'h1234);
    #1;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst f_rd1", f_rd1, 32'h0);
    chk("rst n_rd1", n_rd1, 32'h0);
    chk("rst f_rd2", f_rd2, 32'h0);
    chk("rst f_wc", 32'(f_wc), 32'h0);
    chk("rst f_tv", 32'(f_tv), 32'h0);
    clock_edge();
    reset_n = 1'b1;
    set_in(1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd8);
    #1;
    chk("rst lost write", n_rd1, 32'h0);
    check_trace("after rst");

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      set_in(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom(), $urandom(),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) ra1 = wa;
      if ($urandom_range(0, 3) == 0) ra2 = wa;
      @(negedge clk);
      check_reads($sformatf("rnd%0d", i));
      clock_edge();
      check_trace($sformatf("rnd%0d", i));
    end

    // counter wrap from a clean reset
    reset_n = 1'b0;
    #1;
    model_reset();
    reset_n = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      set_in(1'b1, 5'(1 + (i % 31)), 32'(i), 32'(i), 5'd0, 5'd0);
      clock_edge();
    end
    chk("wrap full", 32'(f_wc), 32'h0000FFFF);
    set_in(1'b1, 5'd9, 32'hABCD, 32'h0, 5'd0, 5'd0);
    clock_edge();
    chk("wrap zero f", 32'(f_wc), 32'h0);
    chk("wrap zero n", 32'(n_wc), 32'h0);
    chk("wrap tv", 32'(f_tv), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
